// File: rtl/scan_display.sv
// scan_display: time-multiplexed driver for a common-anode digit array.
// Scans DIGITS nibbles onto one shared symbol bus, most significant digit
// first, with per-digit blanking, blinking, decimal points and PWM
// brightness. All per-frame inputs are captured at the frame end so a
// frame never mixes old and new values.
module scan_display #(
  parameter int DIGITS       = 6,
  parameter int SUB          = 4,
  parameter int BW           = 3,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                clk_i,
  input  logic                a_reset_i,
  input  logic [4*DIGITS-1:0] digits_i,
  input  logic [DIGITS-1:0]   blank_i,
  input  logic [DIGITS-1:0]   blink_i,
  input  logic [DIGITS-1:0]   dp_i,
  input  logic [BW-1:0]       bright_i,
  output logic [DIGITS-1:0]   dig_o,
  output logic [3:0]          sym_o,
  output logic                dp_o,
  output logic                frame_o
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = (SUB > 1) ? $clog2(SUB) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [SW-1:0] SUB_LAST   = SW'(SUB - 1);
  localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);

  // Slot position is kept as (phase, sub_cnt): cnt = phase*SUB + sub_cnt.
  // This works for any SUB, not only powers of two.
  logic [IW-1:0]       idx;
  logic [SW-1:0]       sub_cnt;
  logic [BW-1:0]       phase;
  logic [FW-1:0]       blink_cnt;
  logic                blink_ph;
  logic                started;

  logic [4*DIGITS-1:0] digits_sh;
  logic [DIGITS-1:0]   blank_sh;
  logic [DIGITS-1:0]   blink_sh;
  logic [DIGITS-1:0]   dp_sh;
  logic [BW-1:0]       bright_sh;

  logic                slot_end;
  logic                frame_end;
  logic                shown;

  assign slot_end  = (sub_cnt == SUB_LAST) && (&phase);
  assign frame_end = slot_end && (idx == '0);

  // Scan position: sub-phase counter, brightness phase and digit index.
  always_ff @(posedge clk_i or negedge a_reset_i) begin
    if (!a_reset_i) begin
      idx     <= IDX_LAST;
      sub_cnt <= '0;
      phase   <= '0;
    end else begin
      if (sub_cnt == SUB_LAST) begin
        sub_cnt <= '0;
        phase   <= phase + 1'b1;
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
      if (slot_end) begin
        idx <= (idx == '0) ? IDX_LAST : idx - 1'b1;
      end
    end
  end

  // Blink timing and frame-pulse enable, both advanced at frame end.
  always_ff @(posedge clk_i or negedge a_reset_i) begin
    if (!a_reset_i) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      started   <= 1'b0;
    end else if (frame_end) begin
      started <= 1'b1;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Shadow copies of the display inputs, captured only at frame end.
  // Blank resets to all ones so the first frame after reset is dark.
  always_ff @(posedge clk_i or negedge a_reset_i) begin
    if (!a_reset_i) begin
      digits_sh <= '0;
      blank_sh  <= '1;
      blink_sh  <= '0;
      dp_sh     <= '0;
      bright_sh <= '0;
    end else if (frame_end) begin
      digits_sh <= digits_i;
      blank_sh  <= blank_i;
      blink_sh  <= blink_i;
      dp_sh     <= dp_i;
      bright_sh <= bright_i;
    end
  end

  // Output decode from registered state only; blank has priority over blink.
  always_comb begin
    shown   = !blank_sh[idx] && !(blink_sh[idx] && blink_ph) && (phase <= bright_sh);
    dig_o   = '1;
    sym_o   = 4'hF;
    dp_o    = 1'b0;
    if (shown) begin
      dig_o[idx] = 1'b0;
      sym_o      = digits_sh[4*idx +: 4];
      dp_o       = dp_sh[idx];
    end
    frame_o = started && (idx == IDX_LAST) && (sub_cnt == '0) && (phase == '0);
  end

endmodule

// File: tb/tb_scan_display.sv
// Directed bench for scan_display with DIGITS=6, SUB=2, BW=2, BLINK_FRAMES=2
// (slot = 8 cycles, frame = 48 cycles). Outputs are sampled on the falling edge.
module tb_scan_display;

  logic        clk = 1'b0;
  logic        a_reset_i;
  logic [23:0] digits;
  logic [5:0]  blank;
  logic [5:0]  blink;
  logic [5:0]  dp;
  logic [1:0]  bright;
  logic [5:0]  dig_o;
  logic [3:0]  sym_o;
  logic        dp_o;
  logic        frame_o;

  int pos;     // cycle within the current frame (0..47)
  int fr;      // frames since the last reset release
  int nchk;
  int nfail;

  logic [5:0] dig_tab [0:5] = '{6'b011111, 6'b101111, 6'b110111,
                                6'b111011, 6'b111101, 6'b111110};
  logic [3:0] up_tab  [0:5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
  logic [3:0] dn_tab  [0:5] = '{4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};

  always #5 clk = ~clk;

  scan_display #(
    .DIGITS      (6),
    .SUB         (2),
    .BW          (2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk_i    (clk),
    .a_reset_i(a_reset_i),
    .digits_i (digits),
    .blank_i  (blank),
    .blink_i  (blink),
    .dp_i     (dp),
    .bright_i (bright),
    .dig_o    (dig_o),
    .sym_o    (sym_o),
    .dp_o     (dp_o),
    .frame_o  (frame_o)
  );

  // Expected {dig, sym, dp, frame} for frame cycle c of frame f given the
  // inputs captured for that frame.
  function automatic logic [11:0] exp_out(input int c, input int f,
                                          input logic [23:0] dv, input logic [5:0] bl,
                                          input logic [5:0] bk, input logic [5:0] dpv,
                                          input logic [1:0] br);
    int d;
    int sp;
    logic ph;
    logic fo;
    logic [5:0] dsel;
    d    = 5 - c / 8;
    sp   = (c % 8) / 2;
    ph   = ((f / 2) % 2) == 1;
    fo   = (c == 0) && (f > 0);
    dsel = 6'h3F;
    if (f == 0 || bl[d] || (bk[d] && ph) || sp > int'(br))
      return {6'h3F, 4'hF, 1'b0, fo};
    dsel[d] = 1'b0;
    return {dsel, dv[d*4 +: 4], dpv[d], fo};
  endfunction

  task automatic tick();
    @(negedge clk);
    pos = pos + 1;
    if (pos == 48) begin
      pos = 0;
      fr  = fr + 1;
    end
  endtask

  task automatic sync_frame();
    tick();
    while (pos != 0) tick();
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    a_reset_i = 1'b0;
    digits = 24'h123456; blank = 6'b0; blink = 6'b0; dp = 6'b0; bright = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nchk++;
      if ({dig_o, sym_o, dp_o, frame_o} !== 12'b111111_1111_0_0) begin
        $display("FAIL reset_hold got=%h exp=%h", {dig_o, sym_o, dp_o, frame_o}, 12'b111111_1111_0_0);
        nfail++;
      end
    end
    @(negedge clk);
    a_reset_i = 1'b1;
    pos = 0;
    fr  = 0;
    for (int c = 0; c < 48; c++) begin
      nchk++;
      if ({dig_o, sym_o, dp_o, frame_o} !== 12'b111111_1111_0_0) begin
        $display("FAIL first_frame_blank c=%0d got=%h exp=%h", c, {dig_o, sym_o, dp_o, frame_o}, 12'b111111_1111_0_0);
        nfail++;
      end
      tick();
    end
    for (int c = 0; c < 48; c++) begin
      exp = {dig_tab[c/8], up_tab[c/8], 1'b0, c == 0};
      nchk++;
      if ({dig_o, sym_o, dp_o, frame_o} !== exp) begin
        $display("FAIL frame1_scan c=%0d got=%h exp=%h", c, {dig_o, sym_o, dp_o, frame_o}, exp);
        nfail++;
      end
      tick();
    end
    nchk++;
    if (frame_o !== 1'b1) begin
      $display("FAIL frame2_pulse got=%b exp=1", frame_o);
      nfail++;
    end
  endtask

  task automatic test_brightness();
    logic [11:0] exp;
    logic [1:0]  br;
    bright = 2'd1;
    sync_frame();
    for (int c = 0; c < 96; c++) begin
      if (c == 20) bright = 2'd0;
      br  = (c < 48) ? 2'd1 : 2'd0;
      exp = exp_out(pos, fr, digits, blank, blink, dp, br);
      nchk++;
      if ({dig_o, sym_o, dp_o, frame_o} !== exp) begin
        $display("FAIL brightness c=%0d got=%h exp=%h", c, {dig_o, sym_o, dp_o, frame_o}, exp);
        nfail++;
      end
      tick();
    end
  endtask

  task automatic test_blink_blank();
    logic [11:0] exp;
    bright = 2'd3; blink = 6'b110000; blank = 6'b000001;
    sync_frame();
    for (int c = 0; c < 4 * 48; c++) begin
      exp = exp_out(pos, fr, digits, blank, blink, dp, bright);
      nchk++;
      if ({dig_o, sym_o, dp_o, frame_o} !== exp) begin
        $display("FAIL blink c=%0d got=%h exp=%h", c, {dig_o, sym_o, dp_o, frame_o}, exp);
        nfail++;
      end
      tick();
    end
    blank = 6'b100001;
    sync_frame();
    for (int c = 0; c < 4 * 48; c++) begin
      exp = exp_out(pos, fr, digits, blank, blink, dp, bright);
      nchk++;
      if ({dig_o, sym_o, dp_o, frame_o} !== exp) begin
        $display("FAIL blank_over_blink c=%0d got=%h exp=%h", c, {dig_o, sym_o, dp_o, frame_o}, exp);
        nfail++;
      end
      tick();
    end
  endtask

  task automatic test_tear_free();
    logic [11:0] exp;
    int s;
    digits = 24'h123456; blank = 6'b0; blink = 6'b0; dp = 6'b0; bright = 2'd3;
    sync_frame();
    for (int c = 0; c < 96; c++) begin
      if (c == 20) digits = 24'h654321;
      s   = (c % 48) / 8;
      exp = {dig_tab[s], (c < 48) ? up_tab[s] : dn_tab[s], 1'b0, (c % 48) == 0};
      nchk++;
      if ({dig_o, sym_o, dp_o, frame_o} !== exp) begin
        $display("FAIL tear_free c=%0d got=%h exp=%h", c, {dig_o, sym_o, dp_o, frame_o}, exp);
        nfail++;
      end
      tick();
    end
  endtask

  task automatic test_decimal_point();
    logic [10:0] exp;
    int s;
    digits = 24'h123456; blank = 6'b0; dp = 6'b001000; bright = 2'd3;
    sync_frame();
    for (int c = 0; c < 48; c++) begin
      s   = c / 8;
      exp = {dig_tab[s], up_tab[s], s == 2};
      nchk++;
      if ({dig_o, sym_o, dp_o} !== exp) begin
        $display("FAIL dp_shown c=%0d got=%h exp=%h", c, {dig_o, sym_o, dp_o}, exp);
        nfail++;
      end
      tick();
    end
    blank = 6'b001000;
    sync_frame();
    for (int c = 0; c < 48; c++) begin
      s   = c / 8;
      exp = (s == 2) ? {6'h3F, 4'hF, 1'b0} : {dig_tab[s], up_tab[s], 1'b0};
      nchk++;
      if ({dig_o, sym_o, dp_o} !== exp) begin
        $display("FAIL dp_blanked c=%0d got=%h exp=%h", c, {dig_o, sym_o, dp_o}, exp);
        nfail++;
      end
      tick();
    end
  endtask

  task automatic test_mid_slot_reset();
    logic [11:0] exp;
    blank = 6'b0; dp = 6'b0; blink = 6'b0; bright = 2'd3; digits = 24'h123456;
    sync_frame();
    while (pos != 19) tick();
    nchk++;
    if ({dig_o, sym_o} !== {6'b110111, 4'h3}) begin
      $display("FAIL pre_reset_digit3 got=%h exp=%h", {dig_o, sym_o}, {6'b110111, 4'h3});
      nfail++;
    end
    a_reset_i = 1'b0;
    #1;
    nchk++;
    if ({dig_o, sym_o, dp_o, frame_o} !== 12'b111111_1111_0_0) begin
      $display("FAIL async_reset got=%h exp=%h", {dig_o, sym_o, dp_o, frame_o}, 12'b111111_1111_0_0);
      nfail++;
    end
    repeat (2) @(negedge clk);
    nchk++;
    if ({dig_o, sym_o, dp_o, frame_o} !== 12'b111111_1111_0_0) begin
      $display("FAIL reset_held got=%h exp=%h", {dig_o, sym_o, dp_o, frame_o}, 12'b111111_1111_0_0);
      nfail++;
    end
    @(negedge clk);
    a_reset_i = 1'b1;
    pos = 0;
    fr  = 0;
    for (int c = 0; c < 96; c++) begin
      exp = (c < 48) ? 12'b111111_1111_0_0
                     : {dig_tab[(c-48)/8], up_tab[(c-48)/8], 1'b0, c == 48};
      nchk++;
      if ({dig_o, sym_o, dp_o, frame_o} !== exp) begin
        $display("FAIL restart_scan c=%0d got=%h exp=%h", c, {dig_o, sym_o, dp_o, frame_o}, exp);
        nfail++;
      end
      tick();
    end
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    pos   = 0;
    fr    = 0;
    test_reset();
    test_brightness();
    test_blink_blank();
    test_tear_free();
    test_decimal_point();
    test_mid_slot_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/scan_display.md
# scan_display

Parametrised time-multiplexed driver for the watch's common-anode digit array. It scans `DIGITS` BCD/hex nibbles onto one shared symbol bus with an active-low digit select, one digit per slot, most significant first. Over a fixed-order scan it adds per-digit blanking, blinking, decimal points, PWM brightness, and tear-free frame-synchronous input capture. It sits between the timekeeping/settings logic and the segment decoder.

## Interface
Parameters:
- `DIGITS`, 6: number of digits scanned, ≥1.
- `SUB`, 4: clock cycles per brightness sub-phase, ≥1.
- `BW`, 3: brightness width; a slot has 2^BW sub-phases.
- `BLINK_FRAMES`, 64: frames per blink half-period, ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` input 1: scan clock.
- `a_reset_i` input 1: asynchronous active-low reset.
- `digits_i` input 4*DIGITS: nibble k at [4k+3:4k]; k=DIGITS-1 is the leftmost digit.
- `blank_i` input DIGITS: bit k=1 suppresses digit k.
- `blink_i` input DIGITS: bit k=1 makes digit k blink.
- `dp_i` input DIGITS: decimal point for digit k.
- `bright_i` input BW: brightness; digit on for sub-phases 0..bright_i.
- `dig_o` output DIGITS: active-low digit select; at most one bit low.
- `sym_o` output 4: nibble for the selected digit; 4'hF when none is selected.
- `dp_o` output 1: decimal point of the selected digit; 0 when none is selected.
- `frame_o` output 1: 1-cycle pulse on the first cycle of each frame.

## Operation
- Scan state registers:
  - `idx`: 0..DIGITS-1, reset DIGITS-1.
  - `cnt`: 0..SUB*2^BW-1, reset 0.
  - `blink_cnt`: 0..BLINK_FRAMES-1, reset 0.
  - `blink_ph`: 1 bit, reset 0.
- `cnt` increments every cycle. At SUB*2^BW-1 it wraps to 0 and `idx` decrements; from 0, `idx` wraps to DIGITS-1.
- Sub-phase = `cnt` / SUB (upper bits when SUB is a power of 2; otherwise a separate sub counter).
- Shadow registers hold `digits_i`, `blank_i`, `blink_i`, `dp_i` and `bright_i`. They load on the edge where idx=0 and cnt=last, i.e. the frame end. Input changes mid-frame never appear until the next frame.
- Shadow reset values: digits 0, blank all ones, blink 0, dp 0, bright 0. The first frame after reset is therefore fully blank.
- Frame end handling:
  - `blink_cnt` increments at every frame end.
  - At BLINK_FRAMES-1 it wraps to 0 and `blink_ph` toggles.
- Digit `idx` is shown when all of these hold:
  - `!blank[idx]`
  - `!(blink[idx] && blink_ph)`
  - sub-phase ≤ bright.
- Shown: `dig_o` = all ones except bit idx = 0, `sym_o` = nibble idx, `dp_o` = dp[idx].
- Not shown: `dig_o` = all ones, `sym_o` = 4'hF, `dp_o` = 0.
- `frame_o` = 1 when idx=DIGITS-1 and cnt=0. It is not asserted in the first cycle after reset release; it first fires one full frame later.
- Outputs are combinational decodes of registers only: no input reaches an output combinationally. The state is a counter, not an enum, so no illegal state exists.
- DIGITS=1: `idx` is constant 0 and every slot end is a frame end.

## Timing
- Slot = SUB*2^BW cycles; frame = DIGITS*slot cycles.
- Reset values: `dig_o` all ones, `sym_o` 4'hF, `dp_o` 0, `frame_o` 0. They take effect immediately on `a_reset_i` falling, independent of `clk_i`.
- Reset asserted mid-frame aborts the scan. After release, scanning restarts at idx=DIGITS-1, cnt=0, with a blank first frame.
- Input latency: a value present on the frame-end edge is displayed from the next cycle. Worst case is one frame plus one cycle.
- Blink: each blink half-period is BLINK_FRAMES frames.
- Simultaneous conditions:
  - blank and blink both set: blank wins, and the digit stays off in both phases.
  - bright_i = 2^BW-1: the digit is on for the whole slot.
  - bright_i = 0: the digit is on for the first SUB cycles only.

## Test plan
All scenarios use DIGITS=6, SUB=2, BW=2, BLINK_FRAMES=2, giving slot = 8 cycles and frame = 48 cycles.
1. Reset and first frame: hold `a_reset_i`=0, then release with `digits_i`=0x123456, `blank_i`=0, `bright_i`=3.
   - During reset and frame 0: `dig_o`=6'b111111, `sym_o`=F.
   - Frame 1: `dig_o`=011111 with `sym_o`=1 for 8 cycles, then 101111/2, 110111/3, 111011/4, 111101/5, 111110/6.
   - `frame_o` pulses every 48 cycles.
2. Brightness: `bright_i`=1, `digits_i`=0x123456.
   - In each slot the digit is selected for cycles 0-3 and `dig_o`=111111, `sym_o`=F for cycles 4-7.
   - A change to `bright_i`=0 applied mid-frame takes effect only from the next frame, giving 2 on-cycles per slot.
3. Blink and blank: `blink_i`=6'b110000, `blank_i`=6'b000001.
   - Digits 5 and 4 are shown for 2 frames, off for 2 frames, repeating.
   - Digit 0 is never selected.
   - Adding `blank_i` bit 5 keeps digit 5 off in both phases.
4. Tear-free update: change `digits_i` from 0x123456 to 0x654321 at cycle 20 of a frame.
   - The remaining slots of that frame still show 3, 4, 5, 6.
   - The next frame shows 6, 5, 4, 3, 2, 1.
5. Decimal point: `dp_i`=6'b001000, `bright_i`=3.
   - `dp_o`=1 only while `dig_o`=110111.
   - With `blank_i`=6'b001000, `dp_o` stays 0.
6. Mid-slot reset: drop `a_reset_i` at cycle 3 of the digit-3 slot.
   - Outputs go to all ones / F / 0 in the same cycle, without a clock edge.
   - After release: one blank frame, then a normal scan starting at digit 5.
